// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: a 2-entry in-order FIFO of {IR, PC} pairs between fetch and decode.
// Optional performance counters (stall_cnt, flush_cnt) are built when IF_ID_PERF_CNT_EN is defined.
module if_id_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_IR,
    input  logic [DATA_W-1:0] in_PC,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_IR,
    output logic [DATA_W-1:0] out_PC,
    output logic [DATA_W-1:0] out_nextPC,
    input  logic              out_ready,
    input  logic              flush
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    logic [1:0]        count_q, count_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] ir_q [2];
    logic [DATA_W-1:0] pc_q [2];

    logic push;
    logic pop;

    // Handshake flags come from registered occupancy only, so out_ready never reaches in_ready.
    assign in_ready  = (count_q != CNT_FULL);
    assign out_valid = (count_q != CNT_EMPTY);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = CNT_EMPTY;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= CNT_EMPTY;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // NOTE: the two storage slots are reset too, so the head outputs are defined (never X) after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                ir_q[i] <= '0;
                pc_q[i] <= '0;
            end
        end else if (push) begin
            ir_q[wr_ptr_q] <= in_IR;
            pc_q[wr_ptr_q] <= in_PC;
        end
    end

    assign out_IR     = ir_q[rd_ptr_q];
    assign out_PC     = pc_q[rd_ptr_q];
    assign out_nextPC = out_PC + DATA_W'(4);

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic        stall_event;
    logic        flush_event;

    // A flush only counts when it actually discards something or kills an attempted push.
    assign stall_event = in_valid && !in_ready && !flush;
    assign flush_event = flush && (out_valid || in_valid);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_event && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush_event && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed vector table, reset corner cases,
// then randomized traffic against a queue-based reference model.
module tb_if_id_buffer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_IR;
    logic [31:0] in_PC;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_IR;
    logic [31:0] out_PC;
    logic [31:0] out_nextPC;
    logic        out_ready;
    logic        flush;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    if_id_buffer #(.DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_IR      (in_IR),
        .in_PC      (in_PC),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_IR     (out_IR),
        .out_PC     (out_PC),
        .out_nextPC (out_nextPC),
        .out_ready  (out_ready),
        .flush      (flush)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] ir;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic        e_valid;
        logic        e_ready;
        logic        e_chk;
        logic [31:0] e_ir;
        logic [31:0] e_pc;
        logic [31:0] e_nxt;
    } vec_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } entry_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ir_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0013;
    endfunction

    function automatic vec_t mk(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                                input logic ordy, input logic fl, input logic e_valid,
                                input logic e_ready, input logic e_chk, input logic [31:0] e_ir,
                                input logic [31:0] e_pc, input logic [31:0] e_nxt);
        vec_t r;
        r.v = v; r.ir = ir; r.pc = pc; r.ordy = ordy; r.fl = fl;
        r.e_valid = e_valid; r.e_ready = e_ready; r.e_chk = e_chk;
        r.e_ir = e_ir; r.e_pc = e_pc; r.e_nxt = e_nxt;
        return r;
    endfunction

    task automatic apply_reset();
        in_valid = 1'b0; in_IR = '0; in_PC = '0; out_ready = 1'b0; flush = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_IR", out_IR, 32'h0);
        check("rst_out_PC", out_PC, 32'h0);
        check("rst_out_nextPC", out_nextPC, 32'h4);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs [12];
    entry_t      model_q [$];
    logic        m_ready, m_valid, do_push, do_pop;
    logic [31:0] m_stall, m_flush;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] flush_before;
`endif

    initial begin
        reset = 1'b0;
        vecs[0]  = mk(1, 32'h00A0_0093, 32'h0, 0, 0, 1, 1, 1, 32'h00A0_0093, 32'h0, 32'h4);
        vecs[1]  = mk(1, ir_of(4), 32'd4, 0, 0, 1, 0, 1, 32'h00A0_0093, 32'h0, 32'h4);
        vecs[2]  = mk(1, ir_of(8), 32'd8, 0, 0, 1, 0, 1, 32'h00A0_0093, 32'h0, 32'h4);
        vecs[3]  = mk(1, ir_of(8), 32'd8, 1, 0, 1, 1, 1, ir_of(4), 32'd4, 32'd8);
        vecs[4]  = mk(1, ir_of(8), 32'd8, 1, 0, 1, 1, 1, ir_of(8), 32'd8, 32'd12);
        vecs[5]  = mk(1, ir_of(12), 32'd12, 1, 0, 1, 1, 1, ir_of(12), 32'd12, 32'd16);
        vecs[6]  = mk(0, 32'h0, 32'h0, 1, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0);
        vecs[7]  = mk(0, 32'h0, 32'h0, 1, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0);
        vecs[8]  = mk(1, ir_of(32'hFFFF_FFFC), 32'hFFFF_FFFC, 0, 0, 1, 1, 1,
                      ir_of(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0);
        vecs[9]  = mk(1, ir_of(16), 32'd16, 0, 0, 1, 0, 1,
                      ir_of(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0);
        vecs[10] = mk(1, ir_of(20), 32'd20, 1, 1, 0, 1, 0, 32'h0, 32'h0, 32'h0);
        vecs[11] = mk(1, ir_of(24), 32'd24, 0, 0, 1, 1, 1, ir_of(24), 32'd24, 32'd28);

        apply_reset();

        // Directed table: each record is one cycle of inputs and the outputs after that edge.
        for (int i = 0; i < 12; i++) begin
            in_valid = vecs[i].v; in_IR = vecs[i].ir; in_PC = vecs[i].pc;
            out_ready = vecs[i].ordy; flush = vecs[i].fl;
`ifdef IF_ID_PERF_CNT_EN
            flush_before = flush_cnt;
`endif
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_valid);
            check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_ready);
            if (vecs[i].e_chk) begin
                check($sformatf("vec%0d_out_IR", i), out_IR, vecs[i].e_ir);
                check($sformatf("vec%0d_out_PC", i), out_PC, vecs[i].e_pc);
                check($sformatf("vec%0d_out_nextPC", i), out_nextPC, vecs[i].e_nxt);
            end
`ifdef IF_ID_PERF_CNT_EN
            if (vecs[i].fl) check($sformatf("vec%0d_flush_cnt", i), flush_cnt, flush_before + 32'd1);
`endif
        end

        // Fill to two entries, then pulse reset mid-cycle: everything must clear at once.
        in_valid = 1'b1; in_IR = ir_of(28); in_PC = 32'd28; out_ready = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        check("full_in_ready", in_ready, 1'b0);
        in_valid = 1'b0; in_IR = '0; in_PC = '0;
        #2;
        reset = 1'b0;
        #1;
        check("async_out_valid", out_valid, 1'b0);
        check("async_out_IR", out_IR, 32'h0);
        check("async_out_PC", out_PC, 32'h0);
        check("async_out_nextPC", out_nextPC, 32'h4);
        check("async_in_ready", in_ready, 1'b1);
        reset = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        check("post_rst_no_entry", out_valid, 1'b0);

        // Randomized traffic against a queue model of the FIFO rules.
        apply_reset();
        model_q.delete();
        m_stall = '0;
        m_flush = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 5);
            in_IR     = $urandom;
            in_PC     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);

            m_ready = (model_q.size() < 2);
            m_valid = (model_q.size() > 0);
            check("rnd_in_ready", in_ready, m_ready);
            check("rnd_out_valid", out_valid, m_valid);
            if (m_valid) begin
                check("rnd_out_IR", out_IR, model_q[0].ir);
                check("rnd_out_PC", out_PC, model_q[0].pc);
                check("rnd_out_nextPC", out_nextPC, model_q[0].pc + 32'd4);
            end

            if (in_valid && !m_ready && !flush && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (flush && (m_valid || in_valid) && m_flush != 32'hFFFF_FFFF) m_flush++;
            if (flush) begin
                model_q.delete();
            end else begin
                do_push = in_valid && m_ready;
                do_pop  = m_valid && out_ready;
                if (do_pop) void'(model_q.pop_front());
                if (do_push) model_q.push_back('{ir: in_IR, pc: in_PC});
            end
            @(posedge clk);
            #1;
        end
`ifdef IF_ID_PERF_CNT_EN
        check("rnd_stall_cnt", stall_cnt, m_stall);
        check("rnd_flush_cnt", flush_cnt, m_flush);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
